// File: rtl/bibus_rr_driver_if.sv
// Channel-side signal bundle for bibus_rr_driver: requests, channel data, capture strobe and status.
// slave = the driver, master = the requesting/observing agent.
interface bibus_rr_driver_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     rd_en;
    logic [NUM_CH-1:0]        gnt;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_valid;
    logic                     conflict;
    logic                     busy;

    modport slave (
        input  req, ch_data, rd_en,
        output gnt, rd_data, rd_valid, conflict, busy
    );

    modport master (
        output req, ch_data, rd_en,
        input  gnt, rd_data, rd_valid, conflict, busy
    );
endinterface

// File: rtl/bibus_rr_driver.sv
// Round-robin arbitrated tri-state driver for a shared bidirectional bus with turnaround and capture.
// Latency: grant/drive one edge after req; capture valid one edge after rd_en; no backpressure (level req).
module bibus_rr_driver #(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 4,
    parameter int HOLD_MAX = 4,
    parameter int TURN_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bibus_rr_driver_if.slave     bus_if,
    inout  wire  [DATA_W-1:0]    data_bus
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    state_e              state_q,    state_d;
    logic [IDX_W-1:0]    owner_q,    owner_d;
    logic [IDX_W-1:0]    last_q,     last_d;
    logic [7:0]          hold_q,     hold_d;
    logic [2:0]          turn_q,     turn_d;
    logic [DATA_W-1:0]   out_q,      out_d;
    logic                drv_en_q,   drv_en_d;
    logic [NUM_CH-1:0]   gnt_q,      gnt_d;
    logic [DATA_W-1:0]   rd_data_q,  rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                conflict_q, conflict_d;

    logic                pick_vld;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    cand;
    logic [DATA_W-1:0]   pick_dat;
    logic [DATA_W-1:0]   own_dat;
    logic                hold_done;

    // Search upward from the channel after the previous owner; first set request wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_CH);
            if (!pick_vld && bus_if.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign pick_dat  = bus_if.ch_data[pick_idx*DATA_W +: DATA_W];
    assign own_dat   = bus_if.ch_data[owner_q*DATA_W +: DATA_W];
    assign hold_done = ((hold_q + 8'd1) >= 8'(HOLD_MAX));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_d     = hold_q;
        turn_d     = turn_q;
        out_d      = out_q;
        drv_en_d   = drv_en_q;
        gnt_d      = gnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        conflict_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus_if.rd_en) begin
                    rd_data_d  = data_bus;
                    rd_valid_d = 1'b1;
                end else if (pick_vld) begin
                    owner_d         = pick_idx;
                    out_d           = pick_dat;
                    drv_en_d        = 1'b1;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    hold_d          = '0;
                    state_d         = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                out_d  = own_dat;
                hold_d = hold_q + 8'd1;
                if (!bus_if.req[owner_q] || hold_done || bus_if.rd_en) begin
                    // An external read during our tenure is a collision: release and flag, never capture.
                    conflict_d = bus_if.rd_en;
                    drv_en_d   = 1'b0;
                    gnt_d      = '0;
                    last_d     = owner_q;
                    turn_d     = 3'(TURN_CYC);
                    state_d    = ST_TURN;
                end
            end
            ST_TURN: begin
                if (turn_q <= 3'd1) begin
                    turn_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    turn_d = turn_q - 3'd1;
                end
            end
            default: begin
                drv_en_d = 1'b0;
                gnt_d    = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            last_q     <= IDX_W'(NUM_CH - 1);
            hold_q     <= '0;
            turn_q     <= '0;
            out_q      <= '0;
            drv_en_q   <= 1'b0;
            gnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
            out_q      <= out_d;
            drv_en_q   <= drv_en_d;
            gnt_q      <= gnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            conflict_q <= conflict_d;
        end
    end

    // The enable is a flop cleared by async reset, so the bus floats the moment rst rises.
    assign data_bus = drv_en_q ? out_q : {DATA_W{1'bz}};

    assign bus_if.gnt      = gnt_q;
    assign bus_if.rd_data  = rd_data_q;
    assign bus_if.rd_valid = rd_valid_q;
    assign bus_if.conflict = conflict_q;
    assign bus_if.busy     = (state_q != ST_IDLE);
endmodule
